// File: rtl/adc_acq_pkg.sv
// rtl/adc_acq_pkg.sv - shared types and constants for the ADC acquisition controller
//
// Purpose: capture state encoding and trigger selector constants used by
//          adc_acq_ctrl and adc_trig_detect.
// Ports:   none (package).

package adc_acq_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRETRIG   = 3'd1,
    WAIT_TRIG = 3'd2,
    POSTTRIG  = 3'd3,
    DONE      = 3'd4
  } acq_state_t;

  localparam logic TRIG_RISING  = 1'b0;
  localparam logic TRIG_FALLING = 1'b1;

  localparam logic TRIG_SRC_A = 1'b0;
  localparam logic TRIG_SRC_B = 1'b1;

endpackage

// File: rtl/adc_trig_detect.sv
// rtl/adc_trig_detect.sv - level-crossing detector on decimated ADC samples
//
// Purpose: compares the current strobe sample of the selected channel with the
//          previous strobe sample against a signed threshold and produces a
//          one-cycle pulse in the same cycle as the strobe.
// Ports:
//   adc_clk, adc_rst        clock, asynchronous active-high reset
//   clr                     forget the previous sample (new capture)
//   strobe                  current cycle carries a decimated sample
//   trig_sel, trig_edge     channel select (A/B), edge select (rising/falling)
//   trig_level              signed threshold
//   dat_a, dat_b            raw channel samples (signed)
//   trig                    crossing detected on this strobe sample

module adc_trig_detect
  import adc_acq_pkg::*;
#(
  parameter int DW = 14
) (
  input  logic          adc_clk,
  input  logic          adc_rst,
  input  logic          clr,
  input  logic          strobe,
  input  logic          trig_sel,
  input  logic          trig_edge,
  input  logic [DW-1:0] trig_level,
  input  logic [DW-1:0] dat_a,
  input  logic [DW-1:0] dat_b,
  output logic          trig
);

  logic [DW-1:0] prev;
  logic          prev_valid;
  logic [DW-1:0] cur;
  logic          rise_hit;
  logic          fall_hit;

  assign cur = (trig_sel == TRIG_SRC_A) ? dat_a : dat_b;

  always_comb begin
    rise_hit = ($signed(prev) <  $signed(trig_level)) && ($signed(cur) >= $signed(trig_level));
    fall_hit = ($signed(prev) >  $signed(trig_level)) && ($signed(cur) <= $signed(trig_level));
  end

  // The first strobe after clr has no predecessor, so it can never cross.
  assign trig = strobe && prev_valid &&
                (((trig_edge == TRIG_RISING)  && rise_hit) ||
                 ((trig_edge == TRIG_FALLING) && fall_hit));

  always_ff @(posedge adc_clk or posedge adc_rst) begin
    if (adc_rst) begin
      prev       <= '0;
      prev_valid <= 1'b0;
    end else if (clr) begin
      prev       <= '0;
      prev_valid <= 1'b0;
    end else if (strobe) begin
      prev       <= cur;
      prev_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/adc_acq_ctrl.sv
// rtl/adc_acq_ctrl.sv - two-channel ADC capture sequencer into a circular buffer
//
// Purpose: decimates channels A/B, writes {B, A} pairs to a circular buffer and
//          sequences arm -> pre-trigger fill -> trigger wait -> post-trigger
//          fill -> done, recording the buffer address of the trigger sample.
// Ports:
//   adc_clk, adc_rst              clock, asynchronous active-high reset
//   adc_dat_a_i, adc_dat_b_i      signed channel samples
//   arm_i, abort_i, trig_sw_i     control pulses
//   trig_sel_i, trig_edge_i,
//   trig_level_i, dec_i,
//   pretrig_i, posttrig_i         capture configuration, latched on arm
//   buf_we_o, buf_addr_o,
//   buf_dat_o                     buffer write port (registered)
//   trig_addr_o                   buffer address of the trigger sample
//   busy_o, triggered_o, done_o   capture status

module adc_acq_ctrl
  import adc_acq_pkg::*;
#(
  parameter int ADC_DATA_WIDTH = 14,
  parameter int ADDR_WIDTH     = 14,
  parameter int DEC_WIDTH      = 17
) (
  input  logic                        adc_clk,
  input  logic                        adc_rst,
  input  logic [ADC_DATA_WIDTH-1:0]   adc_dat_a_i,
  input  logic [ADC_DATA_WIDTH-1:0]   adc_dat_b_i,
  input  logic                        arm_i,
  input  logic                        abort_i,
  input  logic                        trig_sw_i,
  input  logic                        trig_sel_i,
  input  logic                        trig_edge_i,
  input  logic [ADC_DATA_WIDTH-1:0]   trig_level_i,
  input  logic [DEC_WIDTH-1:0]        dec_i,
  input  logic [ADDR_WIDTH-1:0]       pretrig_i,
  input  logic [ADDR_WIDTH-1:0]       posttrig_i,
  output logic                        buf_we_o,
  output logic [ADDR_WIDTH-1:0]       buf_addr_o,
  output logic [2*ADC_DATA_WIDTH-1:0] buf_dat_o,
  output logic [ADDR_WIDTH-1:0]       trig_addr_o,
  output logic                        busy_o,
  output logic                        triggered_o,
  output logic                        done_o
);

  localparam int AW = ADDR_WIDTH;
  localparam logic [AW-1:0]        ADDR_ONE = 1;
  localparam logic [AW:0]          WIDE_ONE = 1;
  localparam logic [DEC_WIDTH-1:0] DEC_ONE  = 1;

  // Keeps pre-trigger + trigger + post-trigger samples within one buffer lap,
  // so post-trigger writes never reach the oldest pre-trigger sample.
  // 2^AW - 1 - pre is simply ~pre in AW bits.
  function automatic logic [AW-1:0] clamp_post(input logic [AW-1:0] pre,
                                               input logic [AW-1:0] post);
    logic [AW:0] sum;
    sum = {1'b0, pre} + {1'b0, post};
    return sum[AW] ? ~pre : post;
  endfunction

  acq_state_t                 state;
  logic [DEC_WIDTH-1:0]       dec_lat;
  logic [DEC_WIDTH-1:0]       dec_cnt;
  logic [DEC_WIDTH-1:0]       dec_max;
  logic [AW-1:0]              pretrig_lat;
  logic [AW-1:0]              posttrig_lat;
  logic                       trig_sel_lat;
  logic                       trig_edge_lat;
  logic [ADC_DATA_WIDTH-1:0]  trig_level_lat;
  logic [AW-1:0]              addr;
  logic [AW-1:0]              pre_cnt;
  logic [AW:0]                pre_next;
  logic [AW:0]                post_rem;
  logic                       strobe;
  logic                       arm_take;
  logic                       level_trig;

  assign dec_max  = (dec_lat == '0) ? '0 : dec_lat - DEC_ONE;
  assign strobe   = (state != IDLE) && (state != DONE) && (dec_cnt == '0);
  assign arm_take = arm_i && !abort_i && ((state == IDLE) || (state == DONE));
  assign pre_next = {1'b0, pre_cnt} + WIDE_ONE;

  adc_trig_detect #(
    .DW (ADC_DATA_WIDTH)
  ) u_trig_detect (
    .adc_clk    (adc_clk),
    .adc_rst    (adc_rst),
    .clr        (arm_take),
    .strobe     (strobe),
    .trig_sel   (trig_sel_lat),
    .trig_edge  (trig_edge_lat),
    .trig_level (trig_level_lat),
    .dat_a      (adc_dat_a_i),
    .dat_b      (adc_dat_b_i),
    .trig       (level_trig)
  );

  always_ff @(posedge adc_clk or posedge adc_rst) begin
    if (adc_rst) begin
      state          <= IDLE;
      dec_lat        <= '0;
      dec_cnt        <= '0;
      pretrig_lat    <= '0;
      posttrig_lat   <= '0;
      trig_sel_lat   <= 1'b0;
      trig_edge_lat  <= 1'b0;
      trig_level_lat <= '0;
      addr           <= '0;
      pre_cnt        <= '0;
      post_rem       <= '0;
      buf_we_o       <= 1'b0;
      buf_addr_o     <= '0;
      buf_dat_o      <= '0;
      trig_addr_o    <= '0;
      busy_o         <= 1'b0;
      triggered_o    <= 1'b0;
      done_o         <= 1'b0;
    end else begin
      buf_we_o <= 1'b0;
      if (abort_i) begin
        // Suppresses the write of this cycle's strobe; trig_addr_o is kept.
        state       <= IDLE;
        busy_o      <= 1'b0;
        done_o      <= 1'b0;
        triggered_o <= 1'b0;
      end else begin
        if (strobe) begin
          buf_we_o   <= 1'b1;
          buf_addr_o <= addr;
          buf_dat_o  <= {adc_dat_b_i, adc_dat_a_i};
          addr       <= addr + ADDR_ONE;
        end
        if ((state != IDLE) && (state != DONE))
          dec_cnt <= (dec_cnt >= dec_max) ? '0 : dec_cnt + DEC_ONE;

        case (state)
          IDLE, DONE: begin
            if (arm_i) begin
              dec_lat        <= dec_i;
              pretrig_lat    <= pretrig_i;
              posttrig_lat   <= clamp_post(pretrig_i, posttrig_i);
              trig_sel_lat   <= trig_sel_i;
              trig_edge_lat  <= trig_edge_i;
              trig_level_lat <= trig_level_i;
              addr           <= '0;
              dec_cnt        <= '0;
              pre_cnt        <= '0;
              busy_o         <= 1'b1;
              done_o         <= 1'b0;
              triggered_o    <= 1'b0;
              state          <= PRETRIG;
            end
          end
          PRETRIG: begin
            if (strobe) begin
              if (pre_next >= {1'b0, pretrig_lat})
                state <= WAIT_TRIG;
              else
                pre_cnt <= pre_cnt + ADDR_ONE;
            end
          end
          WAIT_TRIG: begin
            // Off-strobe, addr already points at the next strobe sample,
            // which becomes the trigger sample and still has to be written.
            if (level_trig || trig_sw_i) begin
              trig_addr_o <= addr;
              triggered_o <= 1'b1;
              if (strobe) begin
                if (posttrig_lat == '0) begin
                  state  <= DONE;
                  busy_o <= 1'b0;
                  done_o <= 1'b1;
                end else begin
                  post_rem <= {1'b0, posttrig_lat};
                  state    <= POSTTRIG;
                end
              end else begin
                post_rem <= {1'b0, posttrig_lat} + WIDE_ONE;
                state    <= POSTTRIG;
              end
            end
          end
          POSTTRIG: begin
            if (strobe) begin
              if (post_rem == WIDE_ONE) begin
                state  <= DONE;
                busy_o <= 1'b0;
                done_o <= 1'b1;
              end else begin
                post_rem <= post_rem - WIDE_ONE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_acq_ctrl.sv
// tb/tb_adc_acq_ctrl.sv - scoreboard testbench for adc_acq_ctrl

module tb_adc_acq_ctrl;

  typedef struct packed {
    logic [13:0] addr;
    logic [27:0] dat;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] adc_a = '0, adc_b = '0, level = '0, pretrig = '0, posttrig = '0;
  logic [16:0] dec = '0;
  logic        arm = 1'b0, arm4 = 1'b0, abort = 1'b0, trig_sw = 1'b0, sel = 1'b0, edg = 1'b0;

  logic        we0, busy0, trgd0, done0;
  logic [13:0] addr0, taddr0;
  logic [27:0] dat0;
  logic        we4, busy4, trgd4, done4;
  logic [3:0]  addr4, taddr4;
  logic [27:0] dat4;

  logic [13:0] a_vals [0:63];
  logic [13:0] b_vals [0:63];
  wr_t q0[$];
  wr_t q4[$];
  wr_t e0, e4;
  int  n_tests = 0;
  int  n_fail = 0;

  always #4 clk = ~clk;

  adc_acq_ctrl #(.ADC_DATA_WIDTH(14), .ADDR_WIDTH(14), .DEC_WIDTH(17)) dut (
    .adc_clk(clk), .adc_rst(rst), .adc_dat_a_i(adc_a), .adc_dat_b_i(adc_b),
    .arm_i(arm), .abort_i(abort), .trig_sw_i(trig_sw), .trig_sel_i(sel),
    .trig_edge_i(edg), .trig_level_i(level), .dec_i(dec), .pretrig_i(pretrig),
    .posttrig_i(posttrig), .buf_we_o(we0), .buf_addr_o(addr0), .buf_dat_o(dat0),
    .trig_addr_o(taddr0), .busy_o(busy0), .triggered_o(trgd0), .done_o(done0)
  );

  adc_acq_ctrl #(.ADC_DATA_WIDTH(14), .ADDR_WIDTH(4), .DEC_WIDTH(17)) dut4 (
    .adc_clk(clk), .adc_rst(rst), .adc_dat_a_i(adc_a), .adc_dat_b_i(adc_b),
    .arm_i(arm4), .abort_i(1'b0), .trig_sw_i(trig_sw), .trig_sel_i(sel),
    .trig_edge_i(edg), .trig_level_i(level), .dec_i(dec), .pretrig_i(pretrig[3:0]),
    .posttrig_i(posttrig[3:0]), .buf_we_o(we4), .buf_addr_o(addr4), .buf_dat_o(dat4),
    .trig_addr_o(taddr4), .busy_o(busy4), .triggered_o(trgd4), .done_o(done4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && we0) begin
      if (q0.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL dut_unexpected_write: got write at addr 0x%0h, expected no write", addr0);
      end else begin
        e0 = q0.pop_front();
        check("dut_wr_addr", 32'(addr0), 32'(e0.addr));
        check("dut_wr_data", 32'(dat0), 32'(e0.dat));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && we4) begin
      if (q4.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL dut4_unexpected_write: got write at addr 0x%0h, expected no write", addr4);
      end else begin
        e4 = q4.pop_front();
        check("dut4_wr_addr", 32'(addr4), 32'(e4.addr));
        check("dut4_wr_data", 32'(dat4), 32'(e4.dat));
      end
    end
  end

  // Expected writes: sample indices first..last (every step), consecutive addresses from 0.
  task automatic push_wr(input int which, input int first, input int last, input int step);
    int  a = 0;
    wr_t w;
    for (int n = first; n <= last; n += step) begin
      w.addr = (which == 0) ? 14'(a) : 14'(a % 16);
      w.dat  = {b_vals[n], a_vals[n]};
      if (which == 0) q0.push_back(w);
      else q4.push_back(w);
      a++;
    end
  endtask

  // Arms one DUT, then scrambles the config inputs and plays the sample table.
  task automatic run_capture(input int which, input int d, input int pre, input int post,
                             input bit s, input bit e, input int lvl,
                             input int sw_at, input int abort_at, input int ncyc);
    @(posedge clk); #1;
    dec = 17'(d); pretrig = 14'(pre); posttrig = 14'(post);
    sel = s; edg = e; level = 14'(lvl);
    if (which == 0) arm = 1'b1;
    else arm4 = 1'b1;
    @(posedge clk); #1;
    arm = 1'b0; arm4 = 1'b0;
    dec = 17'd3; pretrig = 14'd7; posttrig = 14'd9; sel = ~s; edg = ~e; level = 14'd500;
    for (int n = 0; n < ncyc; n++) begin
      adc_a   = a_vals[n];
      adc_b   = b_vals[n];
      trig_sw = (n == sw_at);
      abort   = (n == abort_at);
      arm     = (n == abort_at) && (which == 0);
      @(posedge clk); #1;
    end
    trig_sw = 1'b0; abort = 1'b0; arm = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("reset_we", 32'(we0), 0);
    check("reset_addr", 32'(addr0), 0);
    check("reset_dat", 32'(dat0), 0);
    check("reset_trig_addr", 32'(taddr0), 0);
    check("reset_status", 32'({busy0, trgd0, done0}), 0);

    // Rising ramp on A through 0: trigger at sample 10.
    for (int n = 0; n < 64; n++) begin
      a_vals[n] = 14'(-100 + 10 * n);
      b_vals[n] = 14'd7;
    end
    push_wr(0, 0, 13, 1);
    run_capture(0, 1, 4, 3, 1'b0, 1'b0, 0, -1, -1, 18);
    check("t1_trig_addr", 32'(taddr0), 32'd10);
    check("t1_status", 32'({busy0, trgd0, done0}), 32'b011);
    check("t1_queue_empty", 32'(q0.size()), 0);

    // Crossing inside PRETRIG is ignored; second crossing at sample 20.
    for (int n = 0; n < 64; n++) begin
      if (n < 2) a_vals[n] = 14'(-20 + 10 * n);
      else if (n == 2) a_vals[n] = 14'd0;
      else if (n < 20) a_vals[n] = 14'(-30);
      else a_vals[n] = 14'd10;
      b_vals[n] = 14'(n);
    end
    push_wr(0, 0, 23, 1);
    run_capture(0, 1, 4, 3, 1'b0, 1'b0, 0, -1, -1, 28);
    check("t2_trig_addr", 32'(taddr0), 32'd20);
    check("t2_status", 32'({busy0, trgd0, done0}), 32'b011);
    check("t2_queue_empty", 32'(q0.size()), 0);

    // Decimation 4, software trigger between strobes -> trigger sample 8 at addr 2.
    for (int n = 0; n < 64; n++) begin
      a_vals[n] = 14'(3 * n);
      b_vals[n] = 14'(-n);
    end
    push_wr(0, 0, 16, 4);
    run_capture(0, 4, 0, 2, 1'b0, 1'b0, 0, 5, -1, 24);
    check("t3_trig_addr", 32'(taddr0), 32'd2);
    check("t3_status", 32'({busy0, trgd0, done0}), 32'b011);
    check("t3_queue_empty", 32'(q0.size()), 0);

    // Falling edge on B at -50; -50 -> -60 must not trigger; A decoy falls at sample 1.
    for (int n = 0; n < 64; n++) begin
      a_vals[n] = (n == 0) ? 14'd0 : 14'(-100);
      b_vals[n] = (n == 0) ? 14'(-50) : (n == 1) ? 14'(-60) : (n == 2) ? 14'd0 : 14'(-50);
    end
    push_wr(0, 0, 4, 1);
    run_capture(0, 1, 0, 1, 1'b1, 1'b1, -50, -1, -1, 8);
    check("t5_trig_addr", 32'(taddr0), 32'd3);
    check("t5_status", 32'({busy0, trgd0, done0}), 32'b011);
    check("t5_queue_empty", 32'(q0.size()), 0);

    // 16-entry buffer: posttrig 10 clamped to 5, address wraps 15 -> 0.
    for (int n = 0; n < 64; n++) begin
      a_vals[n] = 14'(-130 + 10 * n);
      b_vals[n] = 14'(-1);
    end
    push_wr(1, 0, 18, 1);
    run_capture(1, 1, 10, 10, 1'b0, 1'b0, 0, -1, -1, 26);
    check("t4_trig_addr", 32'(taddr4), 32'd13);
    check("t4_status", 32'({busy4, trgd4, done4}), 32'b011);
    check("t4_queue_empty", 32'(q4.size()), 0);

    // Abort together with arm during POSTTRIG.
    for (int n = 0; n < 64; n++) begin
      a_vals[n] = 14'd100;
      b_vals[n] = 14'(2 * n);
    end
    push_wr(0, 0, 6, 1);
    run_capture(0, 1, 2, 20, 1'b0, 1'b0, 0, 4, 7, 8);
    check("t6_we_after_abort", 32'(we0), 0);
    check("t6_status", 32'({busy0, trgd0, done0}), 0);
    check("t6_trig_addr_held", 32'(taddr0), 32'd4);
    repeat (3) @(posedge clk);
    #1 check("t6_queue_empty", 32'(q0.size()), 0);

    // Re-arm after abort starts again at address 0.
    push_wr(0, 0, 1, 1);
    run_capture(0, 1, 0, 0, 1'b0, 1'b0, 0, 1, -1, 5);
    check("t7_trig_addr", 32'(taddr0), 32'd1);
    check("t7_status", 32'({busy0, trgd0, done0}), 32'b011);
    check("t7_queue_empty", 32'(q0.size()), 0);

    // Asynchronous reset in the middle of a capture.
    push_wr(0, 0, 1, 1);
    run_capture(0, 1, 100, 0, 1'b0, 1'b0, 0, -1, -1, 3);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_we", 32'(we0), 0);
    check("rst_mid_addr", 32'(addr0), 0);
    check("rst_mid_dat", 32'(dat0), 0);
    check("rst_mid_trig_addr", 32'(taddr0), 0);
    check("rst_mid_status", 32'({busy0, trgd0, done0}), 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("rst_mid_queue_empty", 32'(q0.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_acq_ctrl.md
Name: adc_acq_ctrl

Overview:
Acquisition controller for the two-channel ADC stream on adc_clk. Decimates both channels and writes them as packed sample pairs into an external circular buffer (simple dual-port BRAM, write side only). Sequences the capture: arm, pre-trigger fill, trigger wait, post-trigger fill, done. Records the buffer address of the trigger sample so software can unroll the capture.

Parameters:
ADC_DATA_WIDTH, 14, sample width per channel; samples are signed two's complement.
ADDR_WIDTH, 14, buffer address width; buffer depth is 2^ADDR_WIDTH.
DEC_WIDTH, 17, width of the decimation factor.

Ports:
adc_clk  in  1  ADC sample clock, 125 MHz; sole clock.
adc_rst  in  1  asynchronous, active-high reset.
adc_dat_a_i  in  ADC_DATA_WIDTH  channel A sample, signed.
adc_dat_b_i  in  ADC_DATA_WIDTH  channel B sample, signed.
arm_i  in  1  single-cycle pulse; starts a capture.
abort_i  in  1  single-cycle pulse; cancels the capture.
trig_sw_i  in  1  software trigger pulse.
trig_sel_i  in  1  level-trigger source: 0 = A, 1 = B.
trig_edge_i  in  1  0 = rising, 1 = falling.
trig_level_i  in  ADC_DATA_WIDTH  signed trigger threshold.
dec_i  in  DEC_WIDTH  decimation factor; 0 and 1 both mean every sample.
pretrig_i  in  ADDR_WIDTH  samples required before a trigger is accepted.
posttrig_i  in  ADDR_WIDTH  samples written after the trigger sample.
buf_we_o  out  1  buffer write enable.
buf_addr_o  out  ADDR_WIDTH  buffer write address.
buf_dat_o  out  2*ADC_DATA_WIDTH  packed write data {B, A}.
trig_addr_o  out  ADDR_WIDTH  buffer address of the trigger sample.
busy_o  out  1  high from arm until done or abort.
triggered_o  out  1  high once the trigger has been accepted.
done_o  out  1  capture complete; held high until the next arm, abort or reset.

Behaviour:
- Reset (asynchronous): state IDLE. Every output and internal register is 0.
- All config inputs (trig_sel, edge, level, dec, pretrig, posttrig) are latched on the arm_i cycle. They are ignored at all other times.
- Decimation counter: cleared on arm; counts 0 to D-1, where D = max(dec, 1). The sample strobe is high when count == 0 and the state is not IDLE or DONE.
- On each strobe:
  - The {B, A} pair is written: buf_dat_o, buf_addr_o and buf_we_o are all registered, with 1 cycle of latency from the input sample.
  - The address then increments and wraps modulo 2^ADDR_WIDTH. The address starts at 0 on every arm.
- Level-trigger detector, evaluated on strobe samples only, using the previous strobe sample of the selected channel:
  - rising edge: prev < level and cur >= level.
  - falling edge: prev > level and cur <= level.
  - prev is invalid for the first strobe after arm, so no level trigger is possible on that sample.
- State machine:
  - IDLE: arm_i moves to PRETRIG, with busy = 1, done = 0 and triggered = 0.
  - PRETRIG: writes samples while a pre-trigger counter runs. When the counter reaches the latched pretrig value, move to WAIT_TRIG. pretrig = 0 moves to WAIT_TRIG on the first strobe. Triggers in this state are ignored; prev still updates.
  - WAIT_TRIG: keeps writing circularly. A level trigger on a strobe, or trig_sw_i on any cycle, moves to POSTTRIG.
    - trig_addr_o takes the address of the triggering sample. For a software trigger, it is the address of the next strobe sample.
    - triggered_o goes to 1.
    - The trigger sample itself is written.
  - POSTTRIG: writes posttrig further samples, then moves to DONE. posttrig = 0 means the trigger sample is the last write, and DONE follows it.
  - DONE: done = 1, busy = 0, no writes. arm_i restarts the capture from PRETRIG.
- Clamp: if pretrig + posttrig + 1 > 2^ADDR_WIDTH, posttrig is clamped at arm to 2^ADDR_WIDTH - 1 - pretrig. Pre-trigger data must never be overwritten after the trigger.
- abort_i in any state returns to IDLE on the next edge. busy, done and triggered are cleared; trig_addr_o is held; any in-flight write is suppressed.
- Simultaneous events:
  - abort_i and arm_i together: abort wins.
  - arm_i in PRETRIG, WAIT_TRIG or POSTTRIG is ignored.
  - Level trigger and trig_sw_i on the same cycle: a single trigger at the strobe sample.

Decomposition:
- Package adc_acq_pkg holds:
  - the state enum {IDLE, PRETRIG, WAIT_TRIG, POSTTRIG, DONE};
  - the trigger-edge constants TRIG_RISING = 0 and TRIG_FALLING = 1;
  - the source constants TRIG_SRC_A = 0 and TRIG_SRC_B = 1.
- One sub-module, adc_trig_detect: a registered prev/cur comparator with valid tracking, outputting a single-cycle trig pulse aligned to the strobe.

Test Plan:
- dec = 1, pretrig = 4, posttrig = 3, ramp on A from -100 in steps of 10, level = 0 rising → trigger at the sample with value 0, trig_addr = 10. The last write is at addr 13, then done = 1 and busy = 0.
- Same setup, but A crosses 0 at sample 2 (inside PRETRIG) and again at sample 20 → the first crossing is ignored and trig_addr = 20.
- dec = 4, pretrig = 0, posttrig = 2, trig_sw pulse → a strobe every 4 cycles; exactly 3 writes after the trigger, including the trigger sample; addresses are consecutive.
- ADDR_WIDTH = 4, pretrig = 10, posttrig = 10 → posttrig is clamped to 5; the address wraps 15 → 0; no address written twice after the trigger.
- Falling edge on B with level = -50: B steps 0, -50 → trigger on -50. B steps -50, -60 → no trigger.
- abort during POSTTRIG, with arm asserted in the same cycle → IDLE, buf_we = 0 the next cycle, done = 0. A later arm restarts with address 0. Asserting adc_rst mid-capture zeroes all outputs immediately.
